rv32i_mini_core: RTL and testbench

- Multi-cycle, non-pipelined RV32I integer core with a single 32-bit word-addressed memory bus.
- Exposes CPU control signals (clock, reset, interrupt requests, trap code) and debug signals (last instruction, FSM state).
- Sits between the system memory interconnect and the platform interrupt/trap logic.

---
 rtl/rv32i_mini_core.sv | 260 ++++++++++++++++++++++++++
 tb/tb_rv32i_mini_core.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mini_core.sv
// rv32i_mini_core: multi-cycle, non-pipelined RV32I integer core on a single
// word-addressed memory bus. One instruction walks FETCH -> DECODE -> EXECUTE
// -> (MEM) -> WRITEBACK; any fault parks the core in HALT with a trap code.
// Optional feature: define RISCV_CORE_INTERRUPTS_EN to enable interrupt entry
// on FETCH (vector RESET_PC_ADDRESS+0x10 / +0x20) and MRET return via EPC.
module rv32i_mini_core #(
  parameter int          ADDRESS_SIZE     = 15,
  parameter int          TRAP_SIZE        = 3,
  parameter logic [31:0] RESET_PC_ADDRESS = 32'h2000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              interruptReq,
  input  logic                    memReady,
  input  logic [31:0]             memDataRead,
  output logic [TRAP_SIZE-1:0]    trap,
  output logic [ADDRESS_SIZE-1:0] memAddress,
  output logic                    memStrobe,
  output logic                    memWriteEnable,
  output logic [31:0]             memDataWrite,
  output logic [31:0]             dbgInsnCode,
  output logic [2:0]              dbgState
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [31:0] ECALL_INSN  = 32'h00000073;
  localparam logic [31:0] EBREAK_INSN = 32'h00100073;
  localparam logic [31:0] MRET_INSN   = 32'h30200073;

  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXECUTE = 3'd2, MEM = 3'd3, WRITEBACK = 3'd4, HALT = 3'd7
  } coreState;

  coreState    state;
  logic [31:0] pc, ir, imm, rs1Val, rs2Val, result, nextPc;
  logic [31:0] regFile [32];
  logic [31:0] ea, target, aluOut, pcPlus4;
  logic        taken, altOp, isMemOp, writesRd, unusedBits;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rdIdx;

`ifdef RISCV_CORE_INTERRUPTS_EN
  logic [31:0] epc;
  logic        inHandler;
  assign unusedBits = ^ea[31:ADDRESS_SIZE+2];
`else
  assign unusedBits = ^{ea[31:ADDRESS_SIZE+2], interruptReq};
`endif

  assign opcode   = ir[6:0];
  assign funct3   = ir[14:12];
  assign rdIdx    = ir[11:7];
  assign pcPlus4  = pc + 32'd4;
  assign ea       = rs1Val + imm;
  assign altOp    = ir[30] && (opcode == OP_REG || funct3 == 3'b101);
  assign isMemOp  = (opcode == OP_LOAD) || (opcode == OP_STORE);
  assign writesRd = !(opcode == OP_BRANCH || opcode == OP_STORE || opcode == OP_SYSTEM);
  assign dbgState = state;

  // Classify an instruction: 0 legal, 1 illegal, 4 ECALL, 5 EBREAK.
  function automatic logic [2:0] decodeTrap(input logic [31:0] insn);
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = insn[31:25];
    f3 = insn[14:12];
    decodeTrap = 3'd1;
    case (insn[6:0])
      OP_LUI, OP_AUIPC, OP_JAL: decodeTrap = 3'd0;
      OP_JALR:   if (f3 == 3'b000) decodeTrap = 3'd0;
      OP_BRANCH: if (f3 != 3'b010 && f3 != 3'b011) decodeTrap = 3'd0;
      OP_LOAD, OP_STORE: if (f3 == 3'b010) decodeTrap = 3'd0;
      OP_IMM: begin
        if (f3 == 3'b001) begin
          if (f7 == 7'h00) decodeTrap = 3'd0;
        end else if (f3 == 3'b101) begin
          if (f7 == 7'h00 || f7 == 7'h20) decodeTrap = 3'd0;
        end else begin
          decodeTrap = 3'd0;
        end
      end
      OP_REG: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) decodeTrap = 3'd0;
      OP_SYSTEM: begin
        if (insn == ECALL_INSN) decodeTrap = 3'd4;
        else if (insn == EBREAK_INSN) decodeTrap = 3'd5;
`ifdef RISCV_CORE_INTERRUPTS_EN
        else if (insn == MRET_INSN) decodeTrap = 3'd0;
`endif
      end
      default: decodeTrap = 3'd1;
    endcase
  endfunction

  // Sign-extended immediate for the instruction format implied by the opcode.
  function automatic logic [31:0] formImm(input logic [31:0] insn);
    case (insn[6:0])
      OP_STORE:         formImm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
      OP_BRANCH:        formImm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
      OP_LUI, OP_AUIPC: formImm = {insn[31:12], 12'b0};
      OP_JAL:           formImm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
      default:          formImm = {{20{insn[31]}}, insn[31:20]};
    endcase
  endfunction

  function automatic logic [31:0] aluOp(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] aSigned, bSigned;
    aSigned = a;
    bSigned = b;
    case (f3)
      3'b000:  aluOp = alt ? a - b : a + b;
      3'b001:  aluOp = a << b[4:0];
      3'b010:  aluOp = {31'b0, aSigned < bSigned};
      3'b011:  aluOp = {31'b0, a < b};
      3'b100:  aluOp = a ^ b;
      3'b101:  aluOp = alt ? 32'(aSigned >>> b[4:0]) : a >> b[4:0];
      3'b110:  aluOp = a | b;
      default: aluOp = a & b;
    endcase
  endfunction

  function automatic logic branchTaken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] aSigned, bSigned;
    aSigned = a;
    bSigned = b;
    case (f3)
      3'b000:  branchTaken = a == b;
      3'b001:  branchTaken = a != b;
      3'b100:  branchTaken = aSigned < bSigned;
      3'b101:  branchTaken = aSigned >= bSigned;
      3'b110:  branchTaken = a < b;
      default: branchTaken = a >= b;
    endcase
  endfunction

  // Execute-stage datapath: ALU result, control-transfer target and decision.
  always_comb begin
    aluOut = '0;
    target = pc + imm;
    taken  = 1'b0;
    case (opcode)
      OP_LUI:    aluOut = imm;
      OP_AUIPC:  aluOut = pc + imm;
      OP_JAL:    begin aluOut = pcPlus4; taken = 1'b1; end
      OP_JALR:   begin aluOut = pcPlus4; taken = 1'b1; target = ea & ~32'd1; end
      OP_BRANCH: taken = branchTaken(funct3, rs1Val, rs2Val);
      OP_IMM:    aluOut = aluOp(funct3, altOp, rs1Val, imm);
      OP_REG:    aluOut = aluOp(funct3, altOp, rs1Val, rs2Val);
      default:   aluOut = '0;
    endcase
  end

  // Register file write port; x0 is never written so it always reads zero.
  always_ff @(posedge clock) begin
    if (reset && state == WRITEBACK && writesRd && rdIdx != 5'd0) regFile[rdIdx] <= result;
  end

  // Core sequencer: bus handshakes, decode, trap detection and PC update.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= FETCH;
      pc             <= RESET_PC_ADDRESS;
      trap           <= '0;
      memStrobe      <= 1'b0;
      memWriteEnable <= 1'b0;
      memDataWrite   <= '0;
      dbgInsnCode    <= '0;
      memAddress     <= RESET_PC_ADDRESS[ADDRESS_SIZE+1:2];
`ifdef RISCV_CORE_INTERRUPTS_EN
      inHandler      <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH: begin
          if (!memStrobe) begin
            memStrobe      <= 1'b1;
            memWriteEnable <= 1'b0;
            memAddress     <= pc[ADDRESS_SIZE+1:2];
`ifdef RISCV_CORE_INTERRUPTS_EN
            if (interruptReq != 2'b00 && !inHandler) begin
              epc        <= pc;
              inHandler  <= 1'b1;
              pc         <= RESET_PC_ADDRESS + (interruptReq[0] ? 32'h10 : 32'h20);
              memAddress <= RESET_PC_ADDRESS[ADDRESS_SIZE+1:2] + (interruptReq[0] ? ADDRESS_SIZE'(4) : ADDRESS_SIZE'(8));
            end
`endif
          end else if (memReady) begin
            memStrobe   <= 1'b0;
            ir          <= memDataRead;
            dbgInsnCode <= memDataRead;
            state       <= DECODE;
          end
        end
        DECODE: begin
          rs1Val <= (ir[19:15] == 5'd0) ? 32'd0 : regFile[ir[19:15]];
          rs2Val <= (ir[24:20] == 5'd0) ? 32'd0 : regFile[ir[24:20]];
          imm    <= formImm(ir);
          if (decodeTrap(ir) != 3'd0) begin
            trap  <= TRAP_SIZE'(decodeTrap(ir));
            state <= HALT;
          end else begin
            state <= EXECUTE;
          end
        end
        EXECUTE: begin
          result <= aluOut;
          nextPc <= taken ? target : pcPlus4;
          state  <= WRITEBACK;
`ifdef RISCV_CORE_INTERRUPTS_EN
          if (ir == MRET_INSN) nextPc <= epc;
`endif
          if (taken && target[1:0] != 2'b00) begin
            trap  <= TRAP_SIZE'(2);
            state <= HALT;
          end else if (isMemOp) begin
            if (ea[1:0] != 2'b00) begin
              trap  <= TRAP_SIZE'(3);
              state <= HALT;
            end else begin
              memStrobe      <= 1'b1;
              memWriteEnable <= (opcode == OP_STORE);
              memDataWrite   <= rs2Val;
              memAddress     <= ea[ADDRESS_SIZE+1:2];
              state          <= MEM;
            end
          end
        end
        MEM: begin
          if (memReady) begin
            memStrobe      <= 1'b0;
            memWriteEnable <= 1'b0;
            if (opcode == OP_LOAD) result <= memDataRead;
            state <= WRITEBACK;
          end
        end
        WRITEBACK: begin
          pc    <= nextPc;
          state <= FETCH;
`ifdef RISCV_CORE_INTERRUPTS_EN
          if (ir == MRET_INSN) inHandler <= 1'b0;
`endif
        end
        default: begin
          memStrobe <= 1'b0;
          state     <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_mini_core.sv
// Bench for rv32i_mini_core: a bus-responder memory model with programmable
// wait states, and a scoreboard of expected bus accesses per program.
module tb_rv32i_mini_core;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  interruptReq = 2'b00;
  logic        memReady = 1'b0;
  logic [31:0] memDataRead = 32'h0;
  logic [2:0]  trap;
  logic [14:0] memAddress;
  logic        memStrobe, memWriteEnable;
  logic [31:0] memDataWrite, dbgInsnCode;
  logic [2:0]  dbgState;

  always #5 clock = ~clock;

  rv32i_mini_core dut (
    .clock(clock), .reset(reset), .interruptReq(interruptReq), .memReady(memReady),
    .memDataRead(memDataRead), .trap(trap), .memAddress(memAddress), .memStrobe(memStrobe),
    .memWriteEnable(memWriteEnable), .memDataWrite(memDataWrite), .dbgInsnCode(dbgInsnCode),
    .dbgState(dbgState)
  );

  typedef struct packed {
    logic        we;
    logic [14:0] addr;
    logic [31:0] data;
  } busAccess;

  busAccess    sb[$];
  logic [31:0] mem [0:32767];
  int          vectors = 0, miscompares = 0;
  int          waitTarget = 0, waitCnt = 0, accessCount = 0;
  logic        waiting = 1'b0, justDone = 1'b0;
  logic        heldWe;
  logic [14:0] heldAddr;
  logic [31:0] heldData;

  task automatic clearMem();
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
  endtask

  task automatic expectAccess(input logic we, input logic [14:0] addr, input logic [31:0] data);
    busAccess e;
    e.we = we; e.addr = addr; e.data = data;
    sb.push_back(e);
  endtask

  // One bus cycle, entered and left on a falling edge.
  task automatic step();
    busAccess e;
    memReady    = 1'b0;
    memDataRead = 32'hBAD0BAD0;
    if (memStrobe) begin
      if (justDone) begin
        vectors++; miscompares++;
        $display("FAIL strobe_gap: strobe high right after a completed access, required low");
      end
      if (waiting) begin
        vectors++;
        if (memAddress !== heldAddr || memWriteEnable !== heldWe || (heldWe && memDataWrite !== heldData)) begin
          miscompares++;
          $display("FAIL hold: got addr=0x%0h we=%0d data=0x%0h, required addr=0x%0h we=%0d data=0x%0h",
                   memAddress, memWriteEnable, memDataWrite, heldAddr, heldWe, heldData);
        end
      end else begin
        heldAddr = memAddress; heldWe = memWriteEnable; heldData = memDataWrite; waiting = 1'b1;
      end
      if (waitCnt >= waitTarget) begin
        memReady = 1'b1; waitCnt = 0; waiting = 1'b0; justDone = 1'b1; accessCount++;
        if (memWriteEnable) mem[memAddress] = memDataWrite;
        else memDataRead = mem[memAddress];
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_access: got addr=0x%0h we=%0d, required no access", memAddress, memWriteEnable);
        end else begin
          e = sb.pop_front();
          if (memWriteEnable !== e.we || memAddress !== e.addr || (e.we && memDataWrite !== e.data)) begin
            miscompares++;
            $display("FAIL access: got we=%0d addr=0x%0h data=0x%0h, required we=%0d addr=0x%0h data=0x%0h",
                     memWriteEnable, memAddress, memDataWrite, e.we, e.addr, e.data);
          end
        end
      end else begin
        waitCnt++; justDone = 1'b0;
      end
    end else begin
      justDone = 1'b0; waiting = 1'b0;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic doReset();
    @(negedge clock);
    reset = 1'b0; memReady = 1'b0; interruptReq = 2'b00;
    sb.delete(); waitCnt = 0; waiting = 1'b0; justDone = 1'b0; accessCount = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic runUntilDone(input string name, input int maxCycles);
    for (int c = 0; c < maxCycles && sb.size() != 0; c++) step();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_timeout: %0d accesses outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic checkHalt(input string name, input logic [2:0] expTrap);
    repeat (12) step();
    vectors++;
    if (trap !== expTrap || dbgState !== 3'd7 || memStrobe !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_halt: got trap=%0d state=%0d strobe=%0d, required trap=%0d state=7 strobe=0",
               name, trap, dbgState, memStrobe, expTrap);
    end
  endtask

  task automatic test_alu();
    clearMem(); waitTarget = 0;
    mem[15'h800] = 32'h800000B7; mem[15'h801] = 32'h4040D113; mem[15'h802] = 32'hFFD00193;
    mem[15'h803] = 32'h40218233; mem[15'h804] = 32'h003122B3; mem[15'h805] = 32'h0021B333;
    mem[15'h806] = 32'h10402823; mem[15'h807] = 32'h10502A23; mem[15'h808] = 32'h10602C23;
    mem[15'h809] = 32'h10202E23; mem[15'h80A] = 32'h00029463; mem[15'h80C] = 32'h008003EF;
    mem[15'h80E] = 32'h12702023; mem[15'h80F] = 32'h00001417; mem[15'h810] = 32'h12802223;
    mem[15'h811] = 32'h00000073;
    doReset();
    for (int a = 'h800; a <= 'h806; a++) expectAccess(1'b0, 15'(a), 32'h0);
    expectAccess(1'b1, 15'h44, 32'h07FFFFFD);
    expectAccess(1'b0, 15'h807, 32'h0); expectAccess(1'b1, 15'h45, 32'h1);
    expectAccess(1'b0, 15'h808, 32'h0); expectAccess(1'b1, 15'h46, 32'h0);
    expectAccess(1'b0, 15'h809, 32'h0); expectAccess(1'b1, 15'h47, 32'hF8000000);
    expectAccess(1'b0, 15'h80A, 32'h0); expectAccess(1'b0, 15'h80C, 32'h0);
    expectAccess(1'b0, 15'h80E, 32'h0); expectAccess(1'b1, 15'h48, 32'h00002034);
    expectAccess(1'b0, 15'h80F, 32'h0);
    expectAccess(1'b0, 15'h810, 32'h0); expectAccess(1'b1, 15'h49, 32'h0000303C);
    expectAccess(1'b0, 15'h811, 32'h0);
    runUntilDone("alu", 600);
    checkHalt("ecall", 3'd4);
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b0; memReady = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    vectors++;
    if (memStrobe !== 1'b0 || memWriteEnable !== 1'b0 || trap !== 3'd0 || memDataWrite !== 32'h0 ||
        dbgInsnCode !== 32'h0 || dbgState !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_state: got strobe=%0d we=%0d trap=%0d wdata=0x%0h insn=0x%0h state=%0d, required all 0",
               memStrobe, memWriteEnable, trap, memDataWrite, dbgInsnCode, dbgState);
    end
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    vectors++;
    if (memStrobe !== 1'b1 || memWriteEnable !== 1'b0 || memAddress !== 15'h800 || dbgState !== 3'd0) begin
      miscompares++;
      $display("FAIL first_fetch: got strobe=%0d we=%0d addr=0x%0h state=%0d, required 1 0 0x800 0",
               memStrobe, memWriteEnable, memAddress, dbgState);
    end
  endtask

  task automatic test_reset_abort();
    clearMem(); waitTarget = 5;
    doReset();
    expectAccess(1'b0, 15'h800, 32'h0);
    repeat (2) step();
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    vectors++;
    if (memStrobe !== 1'b0 || dbgState !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_abort: got strobe=%0d state=%0d, required 0 0", memStrobe, dbgState);
    end
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    vectors++;
    if (memStrobe !== 1'b1 || memAddress !== 15'h800) begin
      miscompares++;
      $display("FAIL reset_restart: got strobe=%0d addr=0x%0h, required 1 0x800", memStrobe, memAddress);
    end
  endtask

  task automatic test_store();
    clearMem(); waitTarget = 0;
    mem[15'h800] = 32'h00500093; mem[15'h801] = 32'h10102023;
    doReset();
    expectAccess(1'b0, 15'h800, 32'h0); expectAccess(1'b0, 15'h801, 32'h0);
    expectAccess(1'b1, 15'h040, 32'h5); expectAccess(1'b0, 15'h802, 32'h0);
    runUntilDone("store", 200);
    checkHalt("illegal", 3'd1);
  endtask

  task automatic test_load_wait();
    clearMem(); waitTarget = 3;
    mem[15'h800] = 32'h10402103; mem[15'h801] = 32'h00110193;
    mem[15'h802] = 32'h10302423; mem[15'h803] = 32'h10202623; mem[15'h041] = 32'hDEADBEEF;
    doReset();
    expectAccess(1'b0, 15'h800, 32'h0); expectAccess(1'b0, 15'h041, 32'h0);
    expectAccess(1'b0, 15'h801, 32'h0); expectAccess(1'b0, 15'h802, 32'h0);
    expectAccess(1'b1, 15'h042, 32'hDEADBEF0); expectAccess(1'b0, 15'h803, 32'h0);
    expectAccess(1'b1, 15'h043, 32'hDEADBEEF); expectAccess(1'b0, 15'h804, 32'h0);
    runUntilDone("load_wait", 400);
    checkHalt("load_wait", 3'd1);
  endtask

  task automatic test_misaligned();
    clearMem(); waitTarget = 0;
    mem[15'h800] = 32'h00202103;
    doReset();
    expectAccess(1'b0, 15'h800, 32'h0);
    runUntilDone("misaligned", 100);
    checkHalt("misaligned", 3'd3);
  endtask

`ifdef RISCV_CORE_INTERRUPTS_EN
  task automatic test_interrupt();
    clearMem(); waitTarget = 1;
    mem[15'h800] = 32'h00700093; mem[15'h801] = 32'h10102023;
    mem[15'h802] = 32'h00100073; mem[15'h804] = 32'h30200073;
    doReset();
    expectAccess(1'b0, 15'h800, 32'h0); expectAccess(1'b0, 15'h804, 32'h0);
    expectAccess(1'b0, 15'h801, 32'h0); expectAccess(1'b1, 15'h040, 32'h7);
    expectAccess(1'b0, 15'h802, 32'h0);
    for (int c = 0; c < 100 && accessCount < 1; c++) step();
    interruptReq = 2'b01;
    for (int c = 0; c < 100 && accessCount < 2; c++) step();
    interruptReq = 2'b00;
    runUntilDone("interrupt", 300);
    checkHalt("ebreak", 3'd5);
  endtask
`else
  task automatic test_mret_disabled();
    clearMem(); waitTarget = 0;
    mem[15'h800] = 32'h30200073;
    doReset();
    interruptReq = 2'b01;
    expectAccess(1'b0, 15'h800, 32'h0);
    runUntilDone("mret", 100);
    checkHalt("mret", 3'd1);
    interruptReq = 2'b00;
  endtask
`endif

  initial begin
    test_alu();
    test_reset();
    test_reset_abort();
    test_store();
    test_load_wait();
    test_misaligned();
`ifdef RISCV_CORE_INTERRUPTS_EN
    test_interrupt();
`else
    test_mret_disabled();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
